vx_mem_sram_bridge: RTL and testbench
=====================================

// Module: vx_mem_sram_bridge
// PURPOSE
//  Memory-side responder for one socket memory port: consumes the socket's mem_req stream and drives a
//  single-port SRAM macro with fixed read latency. Returns read data plus tag on the mem_rsp stream.
//  One instance per port, sitting directly downstream of the socket top. Writes generate no response.
//  Credit-based admission guarantees no response is ever dropped under rsp backpressure.
// PARAMETERS
//  ADDR_WIDTH  26   request word address width (line-granular)
//  DATA_WIDTH  512  line data width, bits; byteen width = DATA_WIDTH/8
//  TAG_WIDTH   8    request/response tag width, returned unmodified
//  SRAM_AW     14   SRAM word address width; SRAM_AW <= ADDR_WIDTH
//  SRAM_LAT    1    SRAM read latency, cycles from ce to rdata valid (>=1)
//  RSP_DEPTH   4    response FIFO depth; must be >= SRAM_LAT+2 (elaboration assertion)
// PORTS
//  clk          in   1              clock, all logic rising-edge
//  reset_n      in   1              asynchronous reset, active low
//  req_valid    in   1              request valid
//  req_rw       in   1              1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH     word address
//  req_data     in   DATA_WIDTH     write data
//  req_byteen   in   DATA_WIDTH/8   write byte enables
//  req_tag      in   TAG_WIDTH      request tag
//  req_ready    out  1              request accepted when valid&ready
//  rsp_valid    out  1              read response valid
//  rsp_data     out  DATA_WIDTH     read data
//  rsp_tag      out  TAG_WIDTH      tag of the originating read
//  rsp_ready    in   1              consumer ready
//  sram_ce      out  1              SRAM chip enable (one access per cycle)
//  sram_we      out  1              SRAM write enable
//  sram_addr    out  SRAM_AW        SRAM address
//  sram_wdata   out  DATA_WIDTH     SRAM write data
//  sram_bmask   out  DATA_WIDTH/8   SRAM byte mask = req_byteen
//  sram_rdata   in   DATA_WIDTH     SRAM read data, valid SRAM_LAT cycles after a read ce
//  oor_err      out  1              sticky: out-of-range access seen
//  busy         out  1              any read in flight or response pending
// BEHAVIOUR
//  Reset (reset_n low, async): every output 0 (req_ready 0), FIFO empty, counters 0, oor_err cleared.
//   In-flight reads are discarded. req_ready rises the first cycle after reset_n deasserts.
//  Admission: occupancy = fifo_count + inflight_reads (+1 if issue-stage holds a read).
//   req_ready = (occupancy < RSP_DEPTH). Writes use the same gate for simplicity.
//  Issue stage: accepted request registered. Next cycle sram_ce=1, sram_we=req_rw, sram_addr=req_addr[SRAM_AW-1:0].
//   sram_wdata and sram_bmask are driven from the registered request.
//  Read pipe: SRAM_LAT-deep shift register of {valid, tag, oor}. At stage end, sram_rdata (0 if oor) and tag
//   are pushed into the FIFO.
//  Latency: read accepted in cycle 0 -> sram_ce cycle 1 -> rdata cycle 1+SRAM_LAT -> rsp_valid cycle 2+SRAM_LAT.
//  Response: rsp_valid = FIFO non-empty; rsp_data/rsp_tag = FIFO head, held stable until rsp_valid&rsp_ready.
//   Order is strict FIFO (request order).
//  Throughput: 1 req/cycle sustained while rsp_ready=1; occupancy never exceeds RSP_DEPTH.
//  Simultaneous accept+push+pop in one cycle: all counters update in that same cycle, net change computed
//   arithmetically. No bubble.
//  Out-of-range: req_addr[ADDR_WIDTH-1:SRAM_AW] != 0 sets oor_err (sticky until reset).
//   Out-of-range write: sram_ce suppressed, write dropped.
//   Out-of-range read: sram_ce suppressed; response still returned with data=0 and its original tag.
//  FIFO pointers wrap modulo RSP_DEPTH. Full and empty are distinguished by a count, not by pointer equality.
//  busy = issue-stage valid | any read-pipe valid | FIFO non-empty.
//  Writes retire at sram_ce and are never counted in inflight_reads.
// TESTING
//  Single read, SRAM_LAT=1: preload addr 0x10=0xA5.., read tag 0x3C accepted cycle 0
//   -> rsp_valid cycle 3, data 0xA5.., tag 0x3C.
//  Write then read same addr: write 0xFF byteen=0x0F, then read -> bytes[3:0]=0xFF, upper bytes unchanged.
//   No response for the write.
//  Backpressure: rsp_ready=0, issue 8 back-to-back reads, RSP_DEPTH=4 -> exactly 4 accepted, req_ready=0.
//   Release rsp_ready -> 8 responses, in order, tags 0..7.
//  Streaming: rsp_ready=1, 32 reads back-to-back -> req_ready stays 1; 32 responses on consecutive cycles.
//  Out-of-range read addr=1<<SRAM_AW, tag 0x11 -> sram_ce never asserted; rsp data=0, tag 0x11; oor_err=1
//   and stays 1.
//  Reset mid-stream: reset_n low with 3 reads in flight -> rsp_valid=0 and busy=0 immediately.
//   No stale response after reset_n rises.

Source files
------------

// File: rtl/vx_mem_sram_bridge.sv
// Socket mem_req -> single-port SRAM responder; read rsp_valid 2+SRAM_LAT cycles after accept, strict request order.
// Admission is credit-gated on responses owed, so rsp_ready backpressure stalls req_ready and never drops a response.
module vx_mem_sram_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wrap_inc(wr_q);
      if (pop_i)  rd_q <= wrap_inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = cnt_q;
endmodule

module vx_mem_sram_bridge #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8,
  parameter int SRAM_AW    = 14,
  parameter int SRAM_LAT   = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_byteen,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  input  logic                    rsp_ready,
  output logic                    sram_ce,
  output logic                    sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_bmask,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    oor_err,
  output logic                    busy
);
  localparam int BW = DATA_WIDTH/8;
  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int IW = $clog2(SRAM_LAT+1);
  localparam int OW = $clog2(RSP_DEPTH+SRAM_LAT+3);
  localparam int FW = TAG_WIDTH + DATA_WIDTH;

  if (RSP_DEPTH < SRAM_LAT + 2) begin : g_bad_depth
    $error("vx_mem_sram_bridge: RSP_DEPTH must be >= SRAM_LAT+2");
  end

  logic                  rdy_q, oor_q;
  logic                  iss_vld_q, iss_rw_q, iss_oor_q;
  logic [SRAM_AW-1:0]    iss_addr_q;
  logic [DATA_WIDTH-1:0] iss_data_q;
  logic [BW-1:0]         iss_be_q;
  logic [TAG_WIDTH-1:0]  iss_tag_q;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [SRAM_LAT-1:0]   pv_q, po_q;
  logic [TAG_WIDTH-1:0]  pt_q [SRAM_LAT];
  logic [CW-1:0]         fifo_cnt;
  logic [FW-1:0]         fifo_head, push_dat;
  logic [OW-1:0]         occupancy;
  logic                  req_acc, req_oor, iss_rd, push, pop;

  assign req_acc = req_valid & req_ready;
  assign req_oor = |(req_addr >> SRAM_AW);
  assign iss_rd  = iss_vld_q & ~iss_rw_q;

  // Every accepted read owns one FIFO slot from accept until its response is popped.
  assign occupancy  = OW'(fifo_cnt) + OW'(inflight_q) + OW'(iss_rd);
  assign req_ready  = rdy_q & (occupancy < OW'(RSP_DEPTH));
  assign inflight_d = inflight_q + IW'(iss_rd) - IW'(push);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      oor_q      <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_rw_q   <= 1'b0;
      iss_oor_q  <= 1'b0;
      iss_addr_q <= '0;
      iss_data_q <= '0;
      iss_be_q   <= '0;
      iss_tag_q  <= '0;
      inflight_q <= '0;
    end else begin
      rdy_q      <= 1'b1;
      iss_vld_q  <= req_acc;
      inflight_q <= inflight_d;
      if (req_acc && req_oor) oor_q <= 1'b1;
      if (req_acc) begin
        iss_rw_q   <= req_rw;
        iss_oor_q  <= req_oor;
        iss_addr_q <= req_addr[SRAM_AW-1:0];
        iss_data_q <= req_data;
        iss_be_q   <= req_byteen;
        iss_tag_q  <= req_tag;
      end
    end
  end

  // Read pipe tracks each read alongside the SRAM so tag and data meet at the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_q <= '0;
      po_q <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pt_q[i] <= '0;
    end else begin
      pv_q[0] <= iss_rd;
      po_q[0] <= iss_oor_q;
      pt_q[0] <= iss_tag_q;
      for (int i = 1; i < SRAM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  assign sram_ce    = iss_vld_q & ~iss_oor_q;
  assign sram_we    = sram_ce & iss_rw_q;
  assign sram_addr  = iss_addr_q;
  assign sram_wdata = iss_data_q;
  assign sram_bmask = iss_be_q;

  assign push     = pv_q[SRAM_LAT-1];
  assign push_dat = {pt_q[SRAM_LAT-1], po_q[SRAM_LAT-1] ? {DATA_WIDTH{1'b0}} : sram_rdata};
  assign pop      = rsp_valid & rsp_ready;

  vx_mem_sram_bridge_fifo #(.W(FW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .count_o    (fifo_cnt)
  );

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = rsp_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign rsp_tag   = rsp_valid ? fifo_head[FW-1:DATA_WIDTH] : '0;
  assign oor_err   = oor_q;
  assign busy      = iss_vld_q | (|pv_q) | rsp_valid;
endmodule

// File: tb/tb_vx_mem_sram_bridge.sv
// Bench for vx_mem_sram_bridge: SRAM model, request-level reference model, directed and randomized traffic.
module tb_vx_mem_sram_bridge;
  localparam int AW = 26, DW = 512, TW = 8, SAW = 14, LAT = 1, DEPTH = 4, BW = DW/8;

  logic clk = 1'b0;
  logic reset_n;
  logic req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data, rsp_data, sram_wdata, sram_rdata;
  logic [BW-1:0] req_byteen, sram_bmask;
  logic [TW-1:0] req_tag, rsp_tag;
  logic sram_ce, sram_we, oor_err, busy;
  logic [SAW-1:0] sram_addr;

  vx_mem_sram_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .SRAM_AW(SAW),
                       .SRAM_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_byteen(req_byteen), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_bmask(sram_bmask), .sram_rdata(sram_rdata), .oor_err(oor_err), .busy(busy));

  always #5 clk = ~clk;

  // SRAM macro: one-cycle read latency, byte-masked writes
  bit [DW-1:0] sram_mem [1<<SAW];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_bmask[b]) sram_mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct { logic [DW-1:0] dat; logic [TW-1:0] tag; int avail; } rsp_t;
  bit [DW-1:0] ref_mem [1<<SAW];
  rsp_t exp_q[$];
  rsp_t h;
  int cyc = 0, outstanding = 0, since_rst = 0;
  int n_cmp = 0, n_fail = 0, n_acc = 0, n_ce = 0, acc_cyc_last = 0;
  bit wr_issue = 0, exp_ce = 0, exp_we = 0, oor_exp = 0, m_vld, m_oor, rand_bp = 0;
  logic [SAW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [BW-1:0] exp_be;
  int pop_cyc[$];
  logic [TW-1:0] pop_tag[$];
  logic [DW-1:0] pop_dat[$];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: every accepted read is owed one response, visible 2+LAT cycles after accept, in order.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sram_ce", sram_ce, 0);
      check("rst_oor_err", oor_err, 0);
      exp_q.delete();
      outstanding = 0; wr_issue = 0; exp_ce = 0; oor_exp = 0; since_rst = 0;
    end else begin
      check("req_ready", req_ready, (since_rst > 0 && outstanding < DEPTH));
      check("busy", busy, (outstanding > 0 || wr_issue));
      check("oor_err", oor_err, oor_exp);
      m_vld = exp_q.size() > 0 && exp_q[0].avail <= cyc;
      check("rsp_valid", rsp_valid, m_vld);
      if (rsp_valid && m_vld) begin
        check("rsp_data", rsp_data, exp_q[0].dat);
        check("rsp_tag", rsp_tag, exp_q[0].tag);
      end
      check("sram_ce", sram_ce, exp_ce);
      if (sram_ce) n_ce++;
      if (sram_ce && exp_ce) begin
        check("sram_we", sram_we, exp_we);
        check("sram_addr", sram_addr, exp_addr);
        if (exp_we) begin
          check("sram_wdata", sram_wdata, exp_wdata);
          check("sram_bmask", sram_bmask, exp_be);
        end
      end
      if (rsp_valid && rsp_ready) begin
        pop_cyc.push_back(cyc); pop_tag.push_back(rsp_tag); pop_dat.push_back(rsp_data);
        if (m_vld) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
      end
      wr_issue = 0; exp_ce = 0;
      if (req_valid && req_ready) begin
        n_acc++; acc_cyc_last = cyc;
        m_oor = (req_addr >> SAW) != 0;
        if (m_oor) oor_exp = 1;
        exp_ce = !m_oor; exp_we = req_rw; exp_addr = req_addr[SAW-1:0];
        exp_wdata = req_data; exp_be = req_byteen;
        if (req_rw) begin
          wr_issue = 1;
          if (!m_oor)
            for (int b = 0; b < BW; b++)
              if (req_byteen[b]) ref_mem[req_addr[SAW-1:0]][b*8 +: 8] = req_data[b*8 +: 8];
        end else begin
          h.dat = m_oor ? '0 : ref_mem[req_addr[SAW-1:0]];
          h.tag = req_tag; h.avail = cyc + 2 + LAT;
          exp_q.push_back(h);
          outstanding++;
        end
      end
      since_rst++;
    end
    cyc++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input logic [TW-1:0] t, output int tries);
    bit ok;
    ok = 0; tries = 0;
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d; req_byteen = be; req_tag = t;
    while (!ok && tries < 300) begin
      @(negedge clk); ok = req_ready; tries++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: tag %0h not accepted in %0d cycles", t, tries);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((outstanding > 0 || busy) && k < 500) begin @(posedge clk); #1; k++; end
    if (k >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: outstanding %0d busy %0b", outstanding, busy);
    end
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); pop_tag.delete(); pop_dat.delete();
  endtask

  int tr, stalls, base, ce_base;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic [BW-1:0] rbe;

  initial begin
    reset_n = 1; req_valid = 0; req_rw = 0; req_addr = '0; req_data = '0;
    req_byteen = '0; req_tag = '0; rsp_ready = 1;
    #2 reset_n = 0;
    for (int a = 0; a < 64; a++) begin
      for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
      sram_mem[a] = rd; ref_mem[a] = rd;
    end
    sram_mem[16] = {64{8'hA5}}; ref_mem[16] = {64{8'hA5}};
    sram_mem[32] = {64{8'h5A}}; ref_mem[32] = {64{8'h5A}};
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk); check("ready_first_cycle", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("ready_second_cycle", req_ready, 1);
    @(posedge clk); #1;

    // single read, fixed latency
    clear_logs();
    send(0, 26'h10, '0, '0, 8'h3C, tr);
    wait_drain();
    check("single_count", pop_tag.size(), 1);
    if (pop_tag.size() == 1) begin
      check("single_latency", pop_cyc[0] - acc_cyc_last, 3);
      check("single_data", pop_dat[0], {64{8'hA5}});
      check("single_tag", pop_tag[0], 8'h3C);
    end

    // partial write then read back
    clear_logs();
    send(1, 26'h20, {64{8'hFF}}, 64'h0F, 8'h40, tr);
    send(0, 26'h20, '0, '0, 8'h41, tr);
    wait_drain();
    check("wr_rd_count", pop_tag.size(), 1);
    if (pop_tag.size() == 1) begin
      check("wr_rd_data", pop_dat[0], {{60{8'h5A}}, {4{8'hFF}}});
      check("wr_rd_tag", pop_tag[0], 8'h41);
    end

    // backpressure: credits cap accepted reads at DEPTH
    clear_logs();
    rsp_ready = 0; base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, AW'(i), '0, '0, TW'(i), tr);
      end
      begin
        idle(12);
        @(negedge clk);
        check("bp_accepted", n_acc - base, 4);
        check("bp_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1;
      end
    join
    wait_drain();
    check("bp_rsp_count", pop_tag.size(), 8);
    for (int i = 0; i < 8 && i < pop_tag.size(); i++) check("bp_tag_order", pop_tag[i], i);

    // streaming at full rate
    clear_logs();
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      send(0, AW'(i), '0, '0, TW'(8'h80 + i), tr);
      if (tr != 1) stalls++;
    end
    check("stream_stalls", stalls, 0);
    wait_drain();
    check("stream_count", pop_cyc.size(), 32);
    if (pop_cyc.size() == 32) begin
      check("stream_span", pop_cyc[31] - pop_cyc[0], 31);
      check("stream_last_tag", pop_tag[31], 8'h9F);
    end

    // out-of-range read
    clear_logs();
    ce_base = n_ce;
    send(0, AW'(1 << SAW), '0, '0, 8'h11, tr);
    wait_drain();
    check("oor_no_ce", n_ce - ce_base, 0);
    check("oor_count", pop_tag.size(), 1);
    if (pop_tag.size() == 1) begin
      check("oor_data", pop_dat[0], '0);
      check("oor_tag", pop_tag[0], 8'h11);
    end
    check("oor_err_set", oor_err, 1);
    send(0, 26'h5, '0, '0, 8'h12, tr);
    wait_drain();
    check("oor_err_sticky", oor_err, 1);

    // randomized mixed traffic with random response backpressure
    rand_bp = 1;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          ra = ($urandom_range(0, 15) == 0) ? (AW'(1 << SAW) | AW'($urandom_range(0, 7)))
                                            : AW'($urandom_range(0, 15));
          for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
          rbe = {$urandom, $urandom};
          send(1'($urandom_range(0, 1)), ra, rd, rbe, TW'(i), tr);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_bp = 0;
      end
      begin
        while (rand_bp) begin
          rsp_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        rsp_ready = 1;
      end
    join
    wait_drain();

    // reset with reads in flight
    send(0, 26'h1, '0, '0, 8'h71, tr);
    send(0, 26'h2, '0, '0, 8'h72, tr);
    send(0, 26'h3, '0, '0, 8'h73, tr);
    reset_n = 0;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    idle(2);
    reset_n = 1;
    clear_logs();
    idle(10);
    check("no_stale_rsp", pop_tag.size(), 0);
    check("rst_oor_cleared", oor_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
